// File: rtl/matrix_operand_loader.sv
// Streams 32-bit words into the A/B operand arrays of the 4x4 multiplier,
// then holds them stable until the registered product is ready.
module matrix_operand_loader #(
  parameter int unsigned MULT_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic [127:0] mat_A,
  output logic [127:0] mat_B,
  output logic         start,
  output logic         busy,
  output logic         done,
  input  logic         done_ack
);

  typedef enum logic [1:0] {
    S_LOAD_A,
    S_LOAD_B,
    S_WAIT,
    S_DONE
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   wcnt_q, wcnt_d;
  logic [3:0]   lat_q, lat_d;
  logic         start_q, start_d;
  logic [127:0] mat_a_q, mat_a_d;
  logic [127:0] mat_b_q, mat_b_d;
  logic         acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD_A;
      wcnt_q  <= 2'd0;
      lat_q   <= 4'd0;
      start_q <= 1'b0;
      mat_a_q <= '0;
      mat_b_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      lat_q   <= lat_d;
      start_q <= start_d;
      mat_a_q <= mat_a_d;
      mat_b_q <= mat_b_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    lat_d    = lat_q;
    start_d  = 1'b0;
    mat_a_d  = mat_a_q;
    mat_b_d  = mat_b_q;
    in_ready = (state_q == S_LOAD_A) ||
               (state_q == S_LOAD_B);
    // a word coinciding with clr is dropped
    acc      = in_valid && in_ready && !clr;
    if (clr) begin
      state_d = S_LOAD_A;
      wcnt_d  = 2'd0;
    end else begin
      unique case (state_q)
        S_LOAD_A: begin
          if (acc) begin
            mat_a_d[{wcnt_q, 5'd0} +: 32] = in_data;
            wcnt_d = wcnt_q + 2'd1;
            if (wcnt_q == 2'd3) state_d = S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (acc) begin
            mat_b_d[{wcnt_q, 5'd0} +: 32] = in_data;
            wcnt_d = wcnt_q + 2'd1;
            if (wcnt_q == 2'd3) begin
              state_d = S_WAIT;
              lat_d   = 4'(MULT_LATENCY - 1);
              start_d = 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (lat_q == 4'd0) state_d = S_DONE;
          else               lat_d   = lat_q - 4'd1;
        end
        S_DONE: begin
          if (done_ack) state_d = S_LOAD_A;
        end
        default: state_d = S_LOAD_A;
      endcase
    end
  end

  assign mat_A = mat_a_q;
  assign mat_B = mat_b_q;
  assign start = start_q;
  assign busy  = (state_q == S_WAIT) ||
                 (state_q == S_DONE);
  assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Scoreboard bench for matrix_operand_loader: latency 1 and
// latency 3 instances share stimulus, selected by use3.
module tb_matrix_operand_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        valid = 1'b0;
  logic        done_ack = 1'b0;
  logic        use3 = 1'b0;
  logic [31:0] data = '0;

  logic         r1, s1, b1, d1, r3, s3, b3, d3;
  logic [127:0] a1, bm1, a3, bm3;

  matrix_operand_loader #(.MULT_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(valid & ~use3), .in_ready(r1),
    .in_data(data), .mat_A(a1), .mat_B(bm1),
    .start(s1), .busy(b1), .done(d1),
    .done_ack(done_ack & ~use3)
  );

  matrix_operand_loader #(.MULT_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(valid & use3), .in_ready(r3),
    .in_data(data), .mat_A(a3), .mat_B(bm3),
    .start(s3), .busy(b3), .done(d3),
    .done_ack(done_ack & use3)
  );

  logic         rdy, st, bsy, dn;
  logic [127:0] ma, mb;
  assign rdy = use3 ? r3 : r1;
  assign st  = use3 ? s3 : s1;
  assign bsy = use3 ? b3 : b1;
  assign dn  = use3 ? d3 : d1;
  assign ma  = use3 ? a3 : a1;
  assign mb  = use3 ? bm3 : bm1;

  function automatic logic [127:0] matmul(input logic [127:0] a,
                                          input logic [127:0] b);
    logic [127:0] c;
    logic [7:0]   s;
    logic [15:0]  p;
    c = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 8'd0;
        for (int k = 0; k < 4; k++) begin
          p = a[(4*i+k)*8 +: 8] * b[(4*k+j)*8 +: 8];
          s = s + p[7:0];
        end
        c[(4*i+j)*8 +: 8] = s;
      end
    return c;
  endfunction

  int cyc = 0;
  logic [127:0] c_q = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    c_q <= matmul(ma, mb);
  end

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] c;
    int           cyc;
  } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] ea = '0;
  logic [127:0] eb = '0;
  int mk = 0;
  bit mph = 1'b0;
  int lat = 1;
  int done_at = 0;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] d);
    int n = 0;
    valid = 1'b1;
    data  = d;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      check("send_timeout", 0, 1);
      valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (!mph) ea[mk*32 +: 32] = d;
    else      eb[mk*32 +: 32] = d;
    if (mk == 3) begin
      if (mph)
        sbq.push_back('{ea, eb, matmul(ea, eb), cyc + lat});
      mph = ~mph;
    end
    mk = (mk + 1) % 4;
  endtask

  task automatic wait_done(input bit ack_now);
    int n = 0;
    int bc = 0;
    exp_t e;
    while (!dn && n < 60) begin
      if (bsy) bc++;
      @(negedge clk);
      n++;
    end
    if (!dn) begin
      check("done_timeout", 0, 1);
      return;
    end
    bc++;
    done_at = cyc;
    if (sbq.size() == 0) begin
      check("sb_empty", 0, 1);
      return;
    end
    e = sbq.pop_front();
    check("mat_A", ma, e.a);
    check("mat_B", mb, e.b);
    check("mat_C", c_q, e.c);
    check("done_cyc", cyc, e.cyc);
    check("start_low", st, 0);
    if (ack_now) begin
      check("busy_cycles", bc, lat + 1);
      done_ack = 1'b1;
      @(negedge clk);
      done_ack = 1'b0;
      check("done_drop", dn, 0);
      check("ready_back", rdy, 1);
    end
  endtask

  task automatic load_rand();
    for (int i = 0; i < 8; i++) send($urandom);
    valid = 1'b0;
  endtask

  logic [127:0] a_lit;
  int f;

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", rdy, 1);
    check("rst_start", st, 0);
    check("rst_busy", bsy, 0);
    check("rst_done", dn, 0);
    check("rst_A", ma, 0);
    check("rst_B", mb, 0);

    send(32'h04030201); send(32'h08070605);
    send(32'h0C0B0A09); send(32'h100F0E0D);
    send(32'h00000001); send(32'h00000100);
    send(32'h00010000); send(32'h01000000);
    valid = 1'b0;
    a_lit = 128'h100F0E0D_0C0B0A09_08070605_04030201;
    check("t1_A", ma, a_lit);
    check("t1_start", st, 1);
    check("t1_busy", bsy, 1);
    check("t1_ready", rdy, 0);
    wait_done(1);
    check("t1_C", c_q, a_lit);

    for (int i = 0; i < 8; i++) begin
      send($urandom);
      if (i == 0) f = cyc;
      if (i < 7) begin
        valid = 1'b0;
        data  = $urandom;
        @(negedge clk);
      end
    end
    valid = 1'b0;
    wait_done(1);
    check("stall_span", done_at - f, 15);

    for (int i = 0; i < 8; i++) send($urandom);
    valid = 1'b1;
    data  = 32'hDEADBEEF;
    wait_done(0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready", rdy, 0);
      check("bp_A", ma, ea);
      check("bp_B", mb, eb);
      check("bp_done", dn, 1);
    end
    done_ack = 1'b1;
    @(negedge clk);
    done_ack = 1'b0;
    check("bp_ack_ready", rdy, 1);
    check("bp_ack_A", ma, ea);
    send(32'hDEADBEEF);
    valid = 1'b0;
    check("bp_word", ma[31:0], 32'hDEADBEEF);
    check("bp_A2", ma, ea);

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    mk  = 0;
    mph = 1'b0;
    for (int i = 0; i < 5; i++) send($urandom);
    clr   = 1'b1;
    valid = 1'b1;
    data  = 32'h55AA55AA;
    @(negedge clk);
    clr   = 1'b0;
    valid = 1'b0;
    mk  = 0;
    mph = 1'b0;
    check("clr_ready", rdy, 1);
    check("clr_busy", bsy, 0);
    check("clr_A", ma, ea);
    check("clr_B", mb, eb);
    send(32'h11223344);
    valid = 1'b0;
    check("clr_rewrite", ma, ea);

    use3 = 1'b1;
    lat  = 3;
    ea   = '0;
    eb   = '0;
    mk   = 0;
    mph  = 1'b0;
    @(negedge clk);
    load_rand();
    wait_done(1);
    load_rand();
    wait_done(0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_done", dn, 0);
    check("arst_busy", bsy, 0);
    check("arst_A", ma, 0);
    check("arst_B", mb, 0);
    check("arst_ready", rdy, 1);
    #1 rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
